// File: rtl/dac_frame_sequencer.sv
// Buffers channel-A/B samples and, on each frame tick, emits one A-then-B pair on an Avalon-ST source.
// Tick to srcValid is 2 cycles; srcRdy low holds the current beat stable, and ticks seen while busy are counted and dropped.
module dac_frame_sequencer #(
    parameter int DATA_WIDTH = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int RATE_DIV   = 250,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clrCnt,
    input  logic                  aValid,
    input  logic [DATA_WIDTH-1:0] aData,
    output logic                  aRdy,
    input  logic                  bValid,
    input  logic [DATA_WIDTH-1:0] bData,
    output logic                  bRdy,
    output logic                  srcValid,
    output logic                  srcChannel,
    output logic [DATA_WIDTH-1:0] srcData,
    input  logic                  srcRdy,
    output logic [CNT_WIDTH-1:0]  underrunCntA,
    output logic [CNT_WIDTH-1:0]  underrunCntB,
    output logic [CNT_WIDTH-1:0]  tickMissCnt,
    output logic                  busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(RATE_DIV);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SEND_A = 2'd2;
    localparam logic [1:0] ST_SEND_B = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [CNT_WIDTH-1:0] miss_q, miss_d;
    logic                 tick;
    logic                 load;

    logic [1:0]            in_vld;
    logic [1:0]            rdy;
    logic [DATA_WIDTH-1:0] in_dat   [2];
    logic [DATA_WIDTH-1:0] frame    [2];
    logic [CNT_WIDTH-1:0]  urun     [2];

    assign in_vld    = {bValid, aValid};
    assign in_dat[0] = aData;
    assign in_dat[1] = bData;
    assign load      = (state_q == ST_LOAD);

    always_comb begin
        tick  = enable && (div_q == DW'(RATE_DIV - 1));
        div_d = '0;
        if (enable && !tick) begin
            div_d = div_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (tick) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_SEND_A;
            ST_SEND_A: if (srcRdy) state_d = ST_SEND_B;
            ST_SEND_B: if (srcRdy) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        miss_d = miss_q;
        if (clrCnt) begin
            miss_d = '0;
        end else if (tick && (state_q != ST_IDLE) && (miss_q != '1)) begin
            miss_d = miss_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            miss_q  <= miss_d;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
        logic [AW:0]           wr_q, wr_d, rd_q, rd_d;
        logic [DATA_WIDTH-1:0] frame_q, frame_d;
        logic [CNT_WIDTH-1:0]  urun_q, urun_d;
        logic                  rdy_q, rdy_d;
        logic                  push, pop, empty;

        assign push  = in_vld[ch] & rdy_q;
        assign empty = (wr_q == rd_q);
        assign pop   = load & ~empty;

        // Ready is registered from the next-cycle fill level, so a pop cannot open a slot combinationally.
        always_comb begin
            wr_d    = wr_q + (AW+1)'(push);
            rd_d    = rd_q + (AW+1)'(pop);
            rdy_d   = !((wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]));
            frame_d = pop ? mem_q[rd_q[AW-1:0]] : frame_q;
            urun_d  = urun_q;
            if (clrCnt) begin
                urun_d = '0;
            end else if (load && empty && (urun_q != '1)) begin
                urun_d = urun_q + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_q    <= '0;
                rd_q    <= '0;
                rdy_q   <= 1'b1;
                frame_q <= '0;
                urun_q  <= '0;
            end else begin
                wr_q    <= wr_d;
                rd_q    <= rd_d;
                rdy_q   <= rdy_d;
                frame_q <= frame_d;
                urun_q  <= urun_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_q[AW-1:0]] <= in_dat[ch];
            end
        end

        assign rdy[ch]   = rdy_q;
        assign frame[ch] = frame_q;
        assign urun[ch]  = urun_q;
    end

    assign aRdy         = rdy[0];
    assign bRdy         = rdy[1];
    assign underrunCntA = urun[0];
    assign underrunCntB = urun[1];
    assign tickMissCnt  = miss_q;
    assign busy         = (state_q != ST_IDLE);
    assign srcValid     = (state_q == ST_SEND_A) || (state_q == ST_SEND_B);
    assign srcChannel   = (state_q == ST_SEND_B);
    assign srcData      = (state_q == ST_SEND_A) ? frame[0] :
                          (state_q == ST_SEND_B) ? frame[1] : '0;

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Bench for dac_frame_sequencer: directed scenarios plus random traffic checked against a queue-based frame model.
module tb_dac_frame_sequencer;

    localparam int DW    = 14;
    localparam int DEPTH = 4;
    localparam int RD    = 8;
    localparam int CW    = 8;
    localparam int CMAX  = 255;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          clrCnt = 1'b0;
    logic          aValid = 1'b0;
    logic [DW-1:0] aData = '0;
    logic          aRdy;
    logic          bValid = 1'b0;
    logic [DW-1:0] bData = '0;
    logic          bRdy;
    logic          srcValid;
    logic          srcChannel;
    logic [DW-1:0] srcData;
    logic          srcRdy = 1'b0;
    logic [CW-1:0] underrunCntA;
    logic [CW-1:0] underrunCntB;
    logic [CW-1:0] tickMissCnt;
    logic          busy;

    int n_chk = 0;
    int n_fail = 0;

    dac_frame_sequencer #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RATE_DIV(RD), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .clrCnt(clrCnt),
        .aValid(aValid), .aData(aData), .aRdy(aRdy),
        .bValid(bValid), .bData(bData), .bRdy(bRdy),
        .srcValid(srcValid), .srcChannel(srcChannel), .srcData(srcData), .srcRdy(srcRdy),
        .underrunCntA(underrunCntA), .underrunCntB(underrunCntB),
        .tickMissCnt(tickMissCnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Frame-level model: phase 0 idle, 1 fetching samples, 2 presenting A, 3 presenting B.
    int            m_div;
    int            m_phase;
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [DW-1:0] m_fa, m_fb;
    int            m_ua, m_ub, m_miss;

    function automatic int sat(input int x);
        return (x >= CMAX) ? CMAX : x + 1;
    endfunction

    function automatic logic [DW-1:0] exp_data();
        return (m_phase == 2) ? m_fa : (m_phase == 3) ? m_fb : '0;
    endfunction

    task automatic model_reset();
        m_div = 0; m_phase = 0; m_fa = '0; m_fb = '0;
        m_ua = 0; m_ub = 0; m_miss = 0;
        qa.delete(); qb.delete();
    endtask

    task automatic model_step();
        bit t, pa, pb;
        t  = enable && (m_div == RD - 1);
        pa = aValid && (qa.size() < DEPTH);
        pb = bValid && (qb.size() < DEPTH);
        m_div = (!enable || t) ? 0 : m_div + 1;
        if (t && m_phase != 0) m_miss = sat(m_miss);
        case (m_phase)
            0: if (t) m_phase = 1;
            1: begin
                if (qa.size() > 0) m_fa = qa.pop_front(); else m_ua = sat(m_ua);
                if (qb.size() > 0) m_fb = qb.pop_front(); else m_ub = sat(m_ub);
                m_phase = 2;
            end
            2: if (srcRdy) m_phase = 3;
            default: if (srcRdy) m_phase = 0;
        endcase
        if (pa) qa.push_back(aData);
        if (pb) qb.push_back(bData);
        if (clrCnt) begin m_ua = 0; m_ub = 0; m_miss = 0; end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; clrCnt = 1'b0;
        aValid = 1'b0; bValid = 1'b0; srcRdy = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_chk++; if (srcValid !== 1'b0) begin n_fail++; $display("FAIL reset_srcValid: got %b expected 0", srcValid); end
        do_reset();
        n_chk++; if ({aRdy, bRdy} !== 2'b11) begin n_fail++; $display("FAIL reset_rdy: got %b expected 11", {aRdy, bRdy}); end
        n_chk++; if ({srcValid, srcChannel, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {srcValid, srcChannel, busy}); end
        n_chk++; if (srcData !== '0) begin n_fail++; $display("FAIL reset_srcData: got %h expected 0", srcData); end
        n_chk++; if ({underrunCntA, underrunCntB, tickMissCnt} !== '0) begin n_fail++; $display("FAIL reset_counters: got %h expected 0", {underrunCntA, underrunCntB, tickMissCnt}); end
    endtask

    task automatic test_basic_frame();
        do_reset();
        aValid = 1'b1; aData = 14'h0123; bValid = 1'b1; bData = 14'h3FFF;
        srcRdy = 1'b1; enable = 1'b1;
        step();
        aValid = 1'b0; bValid = 1'b0;
        for (int c = 2; c <= RD + 3; c++) begin
            step();
            n_chk++; if (srcValid !== (c == RD + 1 || c == RD + 2)) begin n_fail++; $display("FAIL basic_valid_c%0d: got %b expected %b", c, srcValid, (c == RD + 1 || c == RD + 2)); end
            if (c == RD + 1) begin
                n_chk++; if ({srcChannel, srcData} !== {1'b0, 14'h0123}) begin n_fail++; $display("FAIL basic_beatA: got ch%b %h expected ch0 0123", srcChannel, srcData); end
            end
            if (c == RD + 2) begin
                n_chk++; if ({srcChannel, srcData} !== {1'b1, 14'h3FFF}) begin n_fail++; $display("FAIL basic_beatB: got ch%b %h expected ch1 3fff", srcChannel, srcData); end
            end
        end
        n_chk++; if (busy !== 1'b0 || qa.size() != 0 || qb.size() != 0) begin n_fail++; $display("FAIL basic_idle: got busy %b expected 0", busy); end
        enable = 1'b0;
    endtask

    task automatic test_fifo_full();
        logic [DW-1:0] beats[$];
        logic [DW-1:0] want[5];
        want = '{14'h0100, 14'h0101, 14'h0102, 14'h0103, 14'h0103};
        do_reset();
        srcRdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            aValid = 1'b1; aData = (i < 4) ? DW'(14'h0100 + i) : 14'h1555;
            step();
            n_chk++; if (aRdy !== (i < 3)) begin n_fail++; $display("FAIL full_aRdy_push%0d: got %b expected %b", i, aRdy, (i < 3)); end
        end
        aValid = 1'b0; enable = 1'b1;
        for (int c = 1; c <= 5 * RD + 4; c++) begin
            if (srcValid && srcRdy && !srcChannel) beats.push_back(srcData);
            step();
            if (c == RD + 3) begin
                n_chk++; if (aRdy !== 1'b1 || qa.size() != 3) begin n_fail++; $display("FAIL full_after_frame_aRdy: got %b expected 1", aRdy); end
            end
        end
        n_chk++; if (beats.size() != 5) begin n_fail++; $display("FAIL full_beat_count: got %0d expected 5", beats.size()); end
        for (int i = 0; i < 5 && i < beats.size(); i++) begin
            n_chk++; if (beats[i] !== want[i]) begin n_fail++; $display("FAIL full_beatA%0d: got %h expected %h", i, beats[i], want[i]); end
        end
        n_chk++; if (underrunCntA !== 8'd1 || underrunCntB !== 8'd5) begin n_fail++; $display("FAIL full_underruns: got A%0d B%0d expected A1 B5", underrunCntA, underrunCntB); end
        enable = 1'b0;
    endtask

    task automatic test_underrun();
        logic [DW:0] beats[$];
        do_reset();
        bValid = 1'b1; bData = 14'h0055; srcRdy = 1'b1; enable = 1'b1;
        step();
        bValid = 1'b0;
        for (int c = 2; c <= RD + 3; c++) begin
            step();
            if (srcValid) beats.push_back({srcChannel, srcData});
        end
        n_chk++; if (beats.size() != 2) begin n_fail++; $display("FAIL underrun_beats: got %0d expected 2", beats.size()); end
        else begin
            n_chk++; if (beats[0] !== {1'b0, 14'h0000}) begin n_fail++; $display("FAIL underrun_beatA: got %h expected 0000", beats[0]); end
            n_chk++; if (beats[1] !== {1'b1, 14'h0055}) begin n_fail++; $display("FAIL underrun_beatB: got %h expected 4055", beats[1]); end
        end
        n_chk++; if (underrunCntA !== 8'd1 || underrunCntB !== 8'd0) begin n_fail++; $display("FAIL underrun_cnt: got A%0d B%0d expected A1 B0", underrunCntA, underrunCntB); end
        enable = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        aValid = 1'b1; aData = 14'h0AAA; bValid = 1'b1; bData = 14'h1BBB;
        srcRdy = 1'b0; enable = 1'b1;
        step();
        aValid = 1'b0; bValid = 1'b0;
        for (int c = 2; c <= RD + 1; c++) step();
        for (int i = 0; i < 20; i++) begin
            n_chk++; if ({srcValid, srcChannel, srcData} !== {2'b10, 14'h0AAA}) begin n_fail++; $display("FAIL hold_cycle%0d: got v%b ch%b %h expected v1 ch0 0aaa", i, srcValid, srcChannel, srcData); end
            if (i < 19) step();
        end
        n_chk++; if (tickMissCnt !== 8'd2 || m_miss != 2) begin n_fail++; $display("FAIL hold_tickMiss: got %0d expected 2", tickMissCnt); end
        srcRdy = 1'b1;
        step();
        n_chk++; if ({srcValid, srcChannel, srcData} !== {2'b11, 14'h1BBB}) begin n_fail++; $display("FAIL hold_release_B: got v%b ch%b %h expected v1 ch1 1bbb", srcValid, srcChannel, srcData); end
        enable = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        srcRdy = 1'b1; enable = 1'b1;
        for (int k = 1; k <= 301 * RD; k++) begin
            step();
            if (k == 300 * RD + 2) begin
                n_chk++; if (underrunCntA !== 8'd255 || underrunCntB !== 8'd255) begin n_fail++; $display("FAIL sat_value: got A%0d B%0d expected 255", underrunCntA, underrunCntB); end
            end
        end
        clrCnt = 1'b1;
        step();
        clrCnt = 1'b0;
        n_chk++; if ({underrunCntA, underrunCntB, tickMissCnt} !== '0) begin n_fail++; $display("FAIL sat_clear: got %h expected 0", {underrunCntA, underrunCntB, tickMissCnt}); end
        enable = 1'b0;
    endtask

    task automatic test_reset_midframe();
        do_reset();
        aValid = 1'b1; bValid = 1'b1; bData = 14'h0222; srcRdy = 1'b0; enable = 1'b1;
        for (int c = 1; c <= RD + 1; c++) begin
            aData = DW'(14'h0111 + c);
            step();
            bValid = 1'b0;
        end
        srcRdy = 1'b1;
        step();
        srcRdy = 1'b0;
        n_chk++; if ({srcValid, srcChannel, srcData} !== {2'b11, 14'h0222}) begin n_fail++; $display("FAIL mid_sendB: got v%b ch%b %h expected v1 ch1 0222", srcValid, srcChannel, srcData); end
        n_chk++; if (aRdy !== 1'b0) begin n_fail++; $display("FAIL mid_fullA: got %b expected 0", aRdy); end
        #2;
        reset = 1'b1;
        #1;
        n_chk++; if ({srcValid, busy, aRdy} !== 3'b001) begin n_fail++; $display("FAIL mid_async: got v%b busy%b aRdy%b expected 0 0 1", srcValid, busy, aRdy); end
        model_reset();
        aValid = 1'b0; srcRdy = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 1; c <= RD + 3; c++) begin
            step();
            n_chk++; if (srcValid !== (c == RD + 1 || c == RD + 2)) begin n_fail++; $display("FAIL mid_restart_c%0d: got %b expected %b", c, srcValid, (c == RD + 1 || c == RD + 2)); end
            if (srcValid) begin
                n_chk++; if (srcData !== '0) begin n_fail++; $display("FAIL mid_flushed_data: got %h expected 0", srcData); end
            end
        end
        n_chk++; if (underrunCntA !== 8'd1 || underrunCntB !== 8'd1) begin n_fail++; $display("FAIL mid_underrun: got A%0d B%0d expected 1 1", underrunCntA, underrunCntB); end
        enable = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            enable = ($urandom_range(0, 39) != 0);
            clrCnt = ($urandom_range(0, 149) == 0);
            aValid = ($urandom_range(0, 5) == 0);
            bValid = ($urandom_range(0, 5) == 0);
            aData  = DW'($urandom);
            bData  = DW'($urandom);
            srcRdy = ($urandom_range(0, 3) != 0);
            step();
            n_chk++; if (srcValid !== (m_phase >= 2)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", i, srcValid, (m_phase >= 2)); end
            if (m_phase >= 2) begin
                n_chk++; if ({srcChannel, srcData} !== {(m_phase == 3), exp_data()}) begin n_fail++; $display("FAIL rnd_beat@%0d: got ch%b %h expected ch%b %h", i, srcChannel, srcData, (m_phase == 3), exp_data()); end
            end
            n_chk++; if (busy !== (m_phase != 0)) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b expected %b", i, busy, (m_phase != 0)); end
            n_chk++; if ({aRdy, bRdy} !== {(qa.size() < DEPTH), (qb.size() < DEPTH)}) begin n_fail++; $display("FAIL rnd_rdy@%0d: got %b expected %b%b", i, {aRdy, bRdy}, (qa.size() < DEPTH), (qb.size() < DEPTH)); end
            n_chk++; if (underrunCntA !== CW'(m_ua) || underrunCntB !== CW'(m_ub) || tickMissCnt !== CW'(m_miss)) begin n_fail++; $display("FAIL rnd_cnt@%0d: got %0d %0d %0d expected %0d %0d %0d", i, underrunCntA, underrunCntB, tickMissCnt, m_ua, m_ub, m_miss); end
        end
        enable = 1'b0; clrCnt = 1'b0; aValid = 1'b0; bValid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_fifo_full();
        test_underrun();
        test_backpressure();
        test_saturation();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
